tlc_phase_timer: RTL and testbench

TLC_PHASE_TIMER -- requirements
Module: tlc_phase_timer

---
 rtl/tlc_pkg.sv | 37 +++
 rtl/tlc_prescaler.sv | 36 +++
 rtl/tlc_phase_timer.sv | 150 +++++++++++++++
 tb/tb_tlc_phase_timer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_pkg
//  Description : Shared phase encoding, FSM state encoding and datapath widths
//                for the traffic-light phase timer and light controller.
//  Revision    : 1.0  initial release
// ============================================================================
package tlc_pkg;

    localparam int PHASE_W = 3;
    localparam int SEC_W   = 8;

    localparam logic [PHASE_W-1:0] PH_S0 = PHASE_W'(0);
    localparam logic [PHASE_W-1:0] PH_S1 = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PH_S2 = PHASE_W'(2);
    localparam logic [PHASE_W-1:0] PH_S3 = PHASE_W'(3);
    localparam logic [PHASE_W-1:0] PH_S4 = PHASE_W'(4);
    localparam logic [PHASE_W-1:0] PH_S5 = PHASE_W'(5);

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_LOAD  = 2'd0;
    localparam logic [ST_W-1:0] ST_COUNT = 2'd1;
    localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;

    function automatic logic [PHASE_W-1:0] f_next_phase(input logic [PHASE_W-1:0] ph);
        return (ph == PH_S5) ? PH_S0 : ph + PHASE_W'(1);
    endfunction

    // Odd phases are yellow, even phases are green.
    function automatic logic [SEC_W-1:0] f_dwell(input logic       odd,
                                                 input logic [SEC_W-1:0] dwell_g,
                                                 input logic [SEC_W-1:0] dwell_y);
        return odd ? dwell_y : dwell_g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_prescaler
//  Description : Enable-gated modulo-TICK_DIV counter producing a one-second
//                tick; the count is held whenever en is low.
//  Revision    : 1.0  initial release
// ============================================================================
module tlc_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned          c_cnt_w = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_last);
    // Gating with en keeps a frozen terminal count from being consumed.
    assign tick   = en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlc_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_phase_timer
//  Description : Six-phase dwell timer issuing step pulses to the light
//                controller, with hold/pause and optional pedestrian
//                shortening (enabled by defining TLC_PED_REQ_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tlc_phase_timer
    import tlc_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DWELL_G  = 10,
    parameter int unsigned DWELL_Y  = 3,
    parameter int unsigned PED_MIN  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               ped_req,
    output logic               step,
    output logic [PHASE_W-1:0] phase,
    output logic [SEC_W-1:0]   sec_left,
    output logic               ped_ack
);

    localparam logic [SEC_W-1:0] c_dwell_g = SEC_W'(DWELL_G);
    localparam logic [SEC_W-1:0] c_dwell_y = SEC_W'(DWELL_Y);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_adv;
    logic [SEC_W-1:0]   r_sec;
    logic               r_step;
    logic               w_run;
    logic               w_tick;
    logic               w_ped_ok;
    logic               w_load;
    logic               w_dec;
    logic               w_adv;
    logic               w_ped;

    // Releasing hold resumes counting in the same cycle, so a hold lasting
    // N cycles shifts the schedule by exactly N cycles.
    assign w_run = !hold && ((r_state == ST_COUNT) || (r_state == ST_PAUSE));

    tlc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_run),
        .tick (w_tick)
    );

`ifdef TLC_PED_REQ_EN
    localparam logic [SEC_W-1:0] c_ped_min = SEC_W'(PED_MIN);
    logic r_ped_ack;

    assign w_ped_ok = ped_req && (r_state == ST_COUNT) && !hold
                      && !r_phase[0] && (r_sec > c_ped_min);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped_ack <= 1'b0;
        end else begin
            r_ped_ack <= w_ped_ok;
        end
    end

    assign ped_ack = r_ped_ack;
`else
    localparam logic [SEC_W-1:0] c_unused_ped_min = SEC_W'(PED_MIN);
    logic w_unused_ped_req;

    assign w_unused_ped_req = ped_req;
    assign w_ped_ok         = 1'b0;
    assign ped_ack          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_LOAD;
        case (r_state)
            ST_LOAD:  w_state_nxt = ST_COUNT;
            ST_COUNT: w_state_nxt = hold ? ST_PAUSE : ST_COUNT;
            ST_PAUSE: w_state_nxt = hold ? ST_PAUSE : ST_COUNT;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    // A pedestrian shortening outranks a coincident tick.
    always_comb begin
        w_load = 1'b0;
        w_dec  = 1'b0;
        w_adv  = 1'b0;
        w_ped  = 1'b0;
        case (r_state)
            ST_LOAD: w_load = 1'b1;
            ST_COUNT, ST_PAUSE: begin
                if (w_ped_ok) begin
                    w_ped = 1'b1;
                end else if (w_tick) begin
                    if (r_sec == SEC_W'(1)) begin
                        w_adv = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_phase_adv = f_next_phase(r_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_S0;
            r_sec   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_step <= w_adv;
            if (w_load) begin
                r_sec <= f_dwell(r_phase[0], c_dwell_g, c_dwell_y);
            end else if (w_adv) begin
                r_phase <= w_phase_adv;
                r_sec   <= f_dwell(w_phase_adv[0], c_dwell_g, c_dwell_y);
            end else if (w_ped) begin
                r_sec <= SEC_W'(PED_MIN);
            end else if (w_dec) begin
                r_sec <= r_sec - SEC_W'(1);
            end
        end
    end

    assign step     = r_step;
    assign phase    = r_phase;
    assign sec_left = r_sec;

endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlc_phase_timer
//  Description : Self-checking bench for tlc_phase_timer (scenario table plus
//                step/ack scoreboard); honours TLC_PED_REQ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tlc_phase_timer;
    import tlc_pkg::*;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DWELL_G  = 5;
    localparam int unsigned DWELL_Y  = 2;
    localparam int unsigned PED_MIN  = 2;
    localparam int          GAP_G    = DWELL_G * TICK_DIV;
    localparam int          GAP_Y    = DWELL_Y * TICK_DIV;
`ifdef TLC_PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    typedef struct {
        string name;
        int    hold_from;
        int    hold_len;
        int    ped_at;
        int    run;
        int    first_step;
        int    chk_at;
        int    chk_ph;
        int    chk_sec;
        bit    ack_exp;
    } scen_t;

    typedef struct {
        int cyc;
        int ph;
        int sec;
    } ev_t;

    logic               clk     = 1'b0;
    logic               rst     = 1'b1;
    logic               hold    = 1'b0;
    logic               ped_req = 1'b0;
    logic               step;
    logic               ped_ack;
    logic [PHASE_W-1:0] phase;
    logic [SEC_W-1:0]   sec_left;

    ev_t   q_step[$];
    ev_t   q_ack[$];
    scen_t tbl[6];
    int    n_cmp     = 0;
    int    n_bad     = 0;
    bit    prev_step = 1'b0;

    always #5 clk = ~clk;

    tlc_phase_timer #(
        .TICK_DIV (TICK_DIV),
        .DWELL_G  (DWELL_G),
        .DWELL_Y  (DWELL_Y),
        .PED_MIN  (PED_MIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .ped_req  (ped_req),
        .step     (step),
        .phase    (phase),
        .sec_left (sec_left),
        .ped_ack  (ped_ack)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_steps(input int first, input int last);
        int cyc = first;
        int ph  = 1;
        while (cyc <= last) begin
            q_step.push_back('{cyc, ph, (ph % 2 == 1) ? int'(DWELL_Y) : int'(DWELL_G)});
            cyc += (ph % 2 == 1) ? GAP_Y : GAP_G;
            ph   = (ph + 1) % 6;
        end
    endtask

    task automatic sample(input int e);
        ev_t ev;
        if (step) begin
            chk("step_consecutive", int'(prev_step), 0);
            if (q_step.size() == 0) begin
                chk("unexpected_step_cycle", e, -1);
            end else begin
                ev = q_step.pop_front();
                chk("step_cycle", e, ev.cyc);
                chk("step_phase", int'(phase), ev.ph);
                chk("step_sec_left", int'(sec_left), ev.sec);
            end
        end
        if (ped_ack) begin
            if (q_ack.size() == 0) begin
                chk("unexpected_ack_cycle", e, -1);
            end else begin
                ev = q_ack.pop_front();
                chk("ack_cycle", e, ev.cyc);
                chk("ack_phase", int'(phase), ev.ph);
                chk("ack_sec_left", int'(sec_left), ev.sec);
            end
        end
        prev_step = step;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        hold    = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_sec_left", int'(sec_left), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_ped_ack", int'(ped_ack), 0);
        prev_step = 1'b0;
        rst = 1'b0;
    endtask

    task automatic run(input int n, input int hold_from, input int hold_len,
                       input int ped_at, input int chk_at, input int chk_ph,
                       input int chk_sec);
        for (int e = 1; e <= n; e++) begin
            hold    = (e >= hold_from) && (e < hold_from + hold_len);
            ped_req = (e == ped_at);
            @(posedge clk);
            #1;
            sample(e);
            if (e == chk_at) begin
                chk("probe_phase", int'(phase), chk_ph);
                chk("probe_sec_left", int'(sec_left), chk_sec);
            end
        end
        hold    = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic end_check();
        chk("pending_steps", q_step.size(), 0);
        chk("pending_acks", q_ack.size(), 0);
        q_step.delete();
        q_ack.delete();
    endtask

    initial begin
        tbl[0] = '{"free_run",     0, 0,  0, 110, 21, 1,  0, 5, 1'b0};
        tbl[1] = '{"hold_10",      8, 10, 0,  50, 31, 17, 0, 4, 1'b0};
        tbl[2] = '{"hold_on_tick", 5, 3,  0,  40, 24, 7,  0, 5, 1'b0};
        tbl[3] = '{"ped_early",    0, 0,  2,  40, PED_EN ? 9 : 21, 2, 0,
                   PED_EN ? int'(PED_MIN) : 5, PED_EN};
        tbl[4] = '{"ped_on_tick",  0, 0,  5,  40, PED_EN ? 13 : 21, 5, 0,
                   PED_EN ? int'(PED_MIN) : 4, PED_EN};
        tbl[5] = '{"ped_yellow",   0, 0, 23,  40, 21, 23, 1, 2, 1'b0};

        foreach (tbl[i]) begin
            do_reset();
            push_steps(tbl[i].first_step, tbl[i].run);
            if (tbl[i].ack_exp) begin
                q_ack.push_back('{tbl[i].ped_at, 0, int'(PED_MIN)});
            end
            run(tbl[i].run, tbl[i].hold_from, tbl[i].hold_len, tbl[i].ped_at,
                tbl[i].chk_at, tbl[i].chk_ph, tbl[i].chk_sec);
            end_check();
        end

        // Reset lands on the very edge that would have advanced phase 3.
        do_reset();
        push_steps(21, 56);
        run(56, 0, 0, 0, 56, 3, 1);
        end_check();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_step", int'(step), 0);
        chk("mid_rst_phase", int'(phase), 0);
        chk("mid_rst_sec_left", int'(sec_left), 0);
        prev_step = 1'b0;
        rst = 1'b0;
        push_steps(21, 30);
        run(30, 0, 0, 0, 1, 0, 5);
        end_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
